// File: rtl/hazard_controller.sv
// Pipeline hazard controller: decides load-use/branch stalls, taken-branch flushes and
// whole-pipe freezes on memory stalls, and keeps saturating stall/flush counters.
module hazard_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ID_Instruction,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_RegWrite,
  input  logic [4:0]  IDEX_WriteReg,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_WriteReg,
  input  logic        BranchTaken,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        PipeFreeze,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
  output logic        dbg_state,
  output logic        dbg_remaining
);

  typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        remaining_q, remaining_d;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic        rs_used, rt_used, is_branch;
  logic        idex_hit, exmem_hit;
  logic [1:0]  stall_n;

  assign opcode = ID_Instruction[31:26];
  assign rs     = ID_Instruction[25:21];
  assign rt     = ID_Instruction[20:16];

  // Source decode and required stall depth for the instruction sitting in ID.
  always_comb begin
    rs_used   = !(opcode == 6'h02 || opcode == 6'h03 || opcode == 6'h0F);
    rt_used   = (opcode == 6'h00 || opcode == 6'h04 || opcode == 6'h05 || opcode == 6'h2B);
    is_branch = (opcode == 6'h04 || opcode == 6'h05);
    idex_hit  = (IDEX_WriteReg != 5'd0) &&
                ((rs_used && rs == IDEX_WriteReg) || (rt_used && rt == IDEX_WriteReg));
    exmem_hit = (EXMEM_WriteReg != 5'd0) &&
                ((rs_used && rs == EXMEM_WriteReg) || (rt_used && rt == EXMEM_WriteReg));
    stall_n   = 2'd0;
    if (is_branch && IDEX_RegWrite && idex_hit && IDEX_MemRead)
      stall_n = 2'd2;
    else if (is_branch && IDEX_RegWrite && idex_hit)
      stall_n = 2'd1;
    else if (is_branch && EXMEM_MemRead && exmem_hit)
      stall_n = 2'd1;
    else if (!is_branch && IDEX_MemRead && idex_hit)
      stall_n = 2'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      remaining_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // A two-deep stall parks in STALL for exactly one extra cycle; MemBusy holds everything.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (!MemBusy) begin
      case (state_q)
        ST_RUN: begin
          if (stall_n == 2'd2) begin
            state_d     = ST_STALL;
            remaining_d = 1'b1;
          end
        end
        ST_STALL: begin
          state_d     = ST_RUN;
          remaining_d = 1'b0;
        end
        default: begin
          state_d     = ST_RUN;
          remaining_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    PipeFreeze = 1'b0;
    if (Reset) begin
      PCWrite = 1'b1;
    end else if (MemBusy) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      PipeFreeze = 1'b1;
    end else if (state_q == ST_STALL || stall_n != 2'd0) begin
      // Taken branches are ignored while bubbling: the branch is re-evaluated after the stall.
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end else begin
      IFIDFlush = BranchTaken;
    end
  end

  // Counters only see bubble/flush, both of which are forced low during a freeze.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      StallCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      if (IDEXBubble && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
      if (IFIDFlush && FlushCount != 16'hFFFF)  FlushCount <= FlushCount + 16'd1;
    end
  end

  assign dbg_state     = state_q;
  assign dbg_remaining = remaining_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: table-driven scenarios plus a randomized
// run, with expected output vectors queued at drive time and compared at the falling edge.
module tb_hazard_controller;

  logic        Clock;
  logic        Reset;
  logic [31:0] ID_Instruction;
  logic        IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
  logic [4:0]  IDEX_WriteReg, EXMEM_WriteReg;
  logic        BranchTaken, MemBusy;
  logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze;
  logic [15:0] StallCount, FlushCount;
  logic        dbg_state, dbg_remaining;

  hazard_controller dut (
    .Clock(Clock), .Reset(Reset), .ID_Instruction(ID_Instruction),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WriteReg(IDEX_WriteReg),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WriteReg(EXMEM_WriteReg),
    .BranchTaken(BranchTaken), .MemBusy(MemBusy),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .IFIDFlush(IFIDFlush),
    .PipeFreeze(PipeFreeze), .StallCount(StallCount), .FlushCount(FlushCount),
    .dbg_state(dbg_state), .dbg_remaining(dbg_remaining)
  );

  // Expected vector order: {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_FLUSH  = 5'b11010;
  localparam logic [4:0] O_STALL  = 5'b00100;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  localparam logic [31:0] I_ADD   = 32'h010A4820;  // R-type, rs=8 rt=10
  localparam logic [31:0] I_BEQ   = 32'h11000003;  // beq rs=8 rt=0
  localparam logic [31:0] I_J     = 32'h09000000;  // j, rs field = 8 but unused
  localparam logic [31:0] I_RS0   = 32'h00004820;  // R-type, rs=0 rt=0
  localparam logic [31:0] I_SW    = 32'hAC080000;  // sw rt=8
  localparam logic [31:0] I_LW    = 32'h8C080000;  // lw rt=8 (destination, not a source)

  typedef struct packed {
    logic [31:0] instr;
    logic        mr, rw;
    logic [4:0]  wr;
    logic        emr;
    logic [4:0]  ewr;
    logic        br, busy, rst;
    logic [4:0]  exp;
  } stim_t;

  logic [4:0]  exp_q[$];
  logic [15:0] stall_m, flush_m;
  int          checks, errors;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic stim_t mk(logic [31:0] instr, logic mr, logic rw, logic [4:0] wr,
                               logic emr, logic [4:0] ewr, logic br, logic busy,
                               logic rst, logic [4:0] exp);
    stim_t s;
    s.instr = instr; s.mr = mr; s.rw = rw; s.wr = wr; s.emr = emr; s.ewr = ewr;
    s.br = br; s.busy = busy; s.rst = rst; s.exp = exp;
    return s;
  endfunction

  task automatic apply(stim_t s);
    ID_Instruction = s.instr;
    IDEX_MemRead   = s.mr;
    IDEX_RegWrite  = s.rw;
    IDEX_WriteReg  = s.wr;
    EXMEM_MemRead  = s.emr;
    EXMEM_WriteReg = s.ewr;
    BranchTaken    = s.br;
    MemBusy        = s.busy;
    Reset          = s.rst;
    exp_q.push_back(s.exp);
  endtask

  // Counter model: what the counters should hold after the coming edge.
  task automatic model_edge(stim_t s, logic [4:0] e);
    if (s.rst) begin
      stall_m = 16'd0;
      flush_m = 16'd0;
    end else begin
      if (e[2] && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
      if (e[1] && flush_m != 16'hFFFF) flush_m = flush_m + 16'd1;
    end
  endtask

  // Independent reading of the stall-depth rules for the randomized run.
  function automatic int ref_depth(stim_t s);
    logic [5:0] op;
    logic [4:0] a, b;
    bit rs_src, rt_src, ex_hit, mem_hit, br;
    op = s.instr[31:26];
    a  = s.instr[25:21];
    b  = s.instr[20:16];
    rs_src  = !(op inside {6'h02, 6'h03, 6'h0F});
    rt_src  = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
    br      = op inside {6'h04, 6'h05};
    ex_hit  = (s.wr != 0) && ((rs_src && a == s.wr) || (rt_src && b == s.wr));
    mem_hit = (s.ewr != 0) && ((rs_src && a == s.ewr) || (rt_src && b == s.ewr));
    if (br) begin
      if (s.rw && ex_hit) return s.mr ? 2 : 1;
      if (s.emr && mem_hit) return 1;
      return 0;
    end
    return (s.mr && ex_hit) ? 1 : 0;
  endfunction

  function automatic stim_t clear_row();
    return mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN);
  endfunction

  task automatic test_reset();
    stim_t rows[$];
    logic [4:0] e;
    rows.push_back(mk(I_BEQ, 1, 1, 5'd8, 1, 5'd8, 1, 1, 1, O_RUN));
    rows.push_back(mk(I_ADD, 1, 0, 5'd8, 0, 5'd0, 1, 0, 1, O_RUN));
    rows.push_back(clear_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL reset[%0d] outputs got %b exp %b", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL reset[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(rows[i], e);
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_hazards();
    stim_t rows[$];
    logic [4:0] e;
    rows.push_back(mk(I_ADD, 1, 0, 5'd8, 0, 5'd0, 0, 0, 0, O_STALL));  // load-use
    rows.push_back(clear_row());
    rows.push_back(mk(I_J,   1, 1, 5'd8, 0, 5'd0, 0, 0, 0, O_RUN));    // J: rs not a source
    rows.push_back(mk(I_RS0, 1, 1, 5'd0, 1, 5'd0, 0, 0, 0, O_RUN));    // r0 never hazards
    rows.push_back(mk(I_SW,  1, 1, 5'd8, 0, 5'd0, 0, 0, 0, O_STALL));  // sw reads rt
    rows.push_back(mk(I_LW,  1, 1, 5'd8, 0, 5'd0, 0, 0, 0, O_RUN));    // lw rt is a destination
    rows.push_back(mk(I_ADD, 0, 1, 5'd10, 0, 5'd0, 0, 0, 0, O_RUN));   // ALU result forwards
    rows.push_back(mk(I_BEQ, 0, 1, 5'd8, 0, 5'd0, 1, 0, 0, O_STALL));  // branch on ALU result
    rows.push_back(mk(I_BEQ, 0, 0, 5'd0, 1, 5'd8, 1, 0, 0, O_STALL));  // branch on MEM load
    rows.push_back(mk(I_BEQ, 0, 0, 5'd0, 0, 5'd8, 1, 0, 0, O_FLUSH));  // EX/MEM not a load
    rows.push_back(clear_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL hazards[%0d] outputs got %b exp %b", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL hazards[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(rows[i], e);
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_load_branch_and_flush();
    stim_t rows[$];
    logic [4:0] e;
    rows.push_back(mk(I_BEQ, 1, 1, 5'd8, 0, 5'd0, 1, 0, 0, O_STALL));
    rows.push_back(mk($urandom(), $urandom_range(0, 1), 0, 5'($urandom_range(0, 31)),
                      0, 5'd0, 1, 0, 0, O_STALL));                      // second stall, inputs arbitrary
    rows.push_back(clear_row());
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, O_FLUSH));
    rows.push_back(mk(I_ADD, 1, 0, 5'd8, 0, 5'd0, 1, 0, 0, O_STALL));  // taken ignored when bubbling
    rows.push_back(clear_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL ldbr_flush[%0d] outputs got %b exp %b", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL ldbr_flush[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(rows[i], e);
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_freeze();
    stim_t rows[$];
    logic [4:0] e;
    rows.push_back(mk(I_BEQ, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0, O_STALL));  // enter STALL
    for (int k = 0; k < 4; k++)
      rows.push_back(mk($urandom(), 1, 1, 5'($urandom_range(0, 31)), 1,
                        5'($urandom_range(0, 31)), 1, 1, 0, O_FREEZE));
    rows.push_back(mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 0, O_STALL)); // held stall resumes
    rows.push_back(clear_row());
    rows.push_back(mk(I_ADD, 1, 0, 5'd8, 0, 5'd0, 1, 1, 0, O_FREEZE)); // busy over a RUN hazard
    rows.push_back(clear_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL freeze[%0d] outputs got %b exp %b", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL freeze[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(rows[i], e);
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [4:0] e;
    logic [5:0] ops[9];
    bit m_stall;
    int n;
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0F, 6'h23, 6'h2B, 6'h08};
    m_stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s.instr = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 16'($urandom())};
      s.mr   = 1'($urandom_range(0, 1));
      s.rw   = 1'($urandom_range(0, 1));
      s.wr   = 5'($urandom_range(0, 3));
      s.emr  = 1'($urandom_range(0, 1));
      s.ewr  = 5'($urandom_range(0, 3));
      s.br   = 1'($urandom_range(0, 1));
      s.busy = ($urandom_range(0, 7) == 0);
      s.rst  = 1'b0;
      n = ref_depth(s);
      if (s.busy) s.exp = O_FREEZE;
      else if (m_stall || n > 0) s.exp = O_STALL;
      else s.exp = s.br ? O_FLUSH : O_RUN;
      if (!s.busy) m_stall = !m_stall && (n == 2);
      apply(s);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL random[%0d] outputs got %b exp %b instr %h", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e, s.instr);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL random[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(s, e);
      @(posedge Clock); #1;
    end
    s = mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_STALL);
    if (!m_stall) s.exp = O_RUN;
    apply(s);
    @(negedge Clock);
    e = exp_q.pop_front();
    model_edge(s, e);
    @(posedge Clock); #1;
  endtask

  task automatic test_saturation_reset();
    stim_t rows[$];
    stim_t pre;
    logic [4:0] e;
    pre = mk(I_ADD, 1, 0, 5'd8, 0, 5'd0, 0, 0, 0, O_STALL);
    // Clear the counters, then preload 0xFFFE stalls.
    apply(mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, O_RUN));
    @(negedge Clock);
    e = exp_q.pop_front();
    model_edge(mk(32'h0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, O_RUN), e);
    @(posedge Clock); #1;
    for (int k = 0; k < 16'hFFFE; k++) begin
      apply(pre);
      @(negedge Clock);
      e = exp_q.pop_front();
      model_edge(pre, e);
      @(posedge Clock); #1;
    end
    for (int k = 0; k < 3; k++) rows.push_back(pre);
    rows.push_back(mk(I_BEQ, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0, O_STALL));  // into STALL at 0xFFFF
    rows.push_back(mk(I_BEQ, 1, 1, 5'd8, 0, 5'd0, 1, 1, 1, O_RUN));    // reset aborts the stall
    rows.push_back(clear_row());                                      // evaluated in RUN
    rows.push_back(clear_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== e) begin
        errors++;
        $display("FAIL sat_reset[%0d] outputs got %b exp %b", i,
                 {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze}, e);
      end
      checks++;
      if (StallCount !== stall_m || FlushCount !== flush_m) begin
        errors++;
        $display("FAIL sat_reset[%0d] counters got %h/%h exp %h/%h", i, StallCount, FlushCount, stall_m, flush_m);
      end
      model_edge(rows[i], e);
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    stall_m = 16'd0;
    flush_m = 16'd0;
    ID_Instruction = 32'h0;
    IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_WriteReg = 5'd0;
    EXMEM_MemRead = 0; EXMEM_WriteReg = 5'd0;
    BranchTaken = 0; MemBusy = 0;
    Reset = 1'b1;
    @(posedge Clock); #1;
    test_reset();
    test_hazards();
    test_load_branch_and_flush();
    test_freeze();
    test_random();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
